// File: rtl/sec_sched_pkg.sv
// Shared types and defaults for the SEC decoder front-end scheduler.
// Holds the FSM state encoding and the default codeword/location widths.
package sec_sched_pkg;

  localparam int W_BITS = 36;
  localparam int N_BITS = 29;

  localparam logic [N_BITS-1:0] SEC_NOT_FOUND = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

endpackage

// File: rtl/sec_rr_arb2.sv
// Two-way round-robin grant: ties go to the requester opposite last_grant.
// Pure combinational; the grant register lives in the scheduler.
module sec_rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       gnt_any
);

  always_comb begin
    gnt_any = |req_valid;
    gnt_idx = 1'b0;
    unique case (1'b1)
      (req_valid == 2'b11): gnt_idx = ~last_grant;
      (req_valid == 2'b10): gnt_idx = 1'b1;
      default:              gnt_idx = 1'b0;
    endcase
    gnt = gnt_any ? (2'b01 << gnt_idx) : 2'b00;
  end

endmodule

// File: rtl/sec_decode_scheduler.sv
// Arbitrates two requesters onto the shared SEC location decoder.
// Optional WAIT timeout abort is enabled by SEC_SCHED_TIMEOUT_EN.
module sec_decode_scheduler
  import sec_sched_pkg::*;
#(
  parameter int W_BITS  = 36,
  parameter int N_BITS  = 29,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [W_BITS-1:0] req_w0,
  input  logic [W_BITS-1:0] req_w1,
  output logic [W_BITS-1:0] dec_w,
  output logic              dec_start,
  input  logic              dec_found,
  input  logic [N_BITS-1:0] dec_n,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [N_BITS-1:0] rsp_n,
  output logic              rsp_timeout
);

  state_t state;
  logic   last_grant;
  logic   blank;
  logic   to_hit;
  logic   found_ok;
  logic   gnt_idx;
  logic   gnt_any;
  logic [1:0] gnt;

  sec_rr_arb2 u_arb (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  assign req_ready = (state == S_IDLE) ? gnt : 2'b00;
  assign found_ok  = dec_found & ~blank;

`ifdef SEC_SCHED_TIMEOUT_EN
  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == S_ISSUE) begin
      cnt <= '0;
    end else if (state == S_WAIT) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign to_hit = (cnt == 8'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      blank       <= 1'b0;
      dec_w       <= '0;
      dec_start   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_n       <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      dec_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (gnt_any) begin
            dec_w      <= gnt_idx ? req_w1 : req_w0;
            rsp_id     <= gnt_idx;
            last_grant <= gnt_idx;
            dec_start  <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // first WAIT cycle ignores a found level left from the old word
          blank <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          blank <= 1'b0;
          if (found_ok) begin
            rsp_n       <= dec_n;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (to_hit) begin
            rsp_n       <= '1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_decode_scheduler.sv
// Bench for sec_decode_scheduler: directed vector table, random traffic
// against a transaction-timing model, and an asynchronous reset check.
module tb_sec_decode_scheduler;

  localparam int W  = 36;
  localparam int N  = 29;
  localparam int TO = 8;
`ifdef SEC_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_w0;
  logic [W-1:0] req_w1;
  logic [W-1:0] dec_w;
  logic         dec_start;
  logic         dec_found;
  logic [N-1:0] dec_n;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_n;
  logic         rsp_timeout;

  sec_decode_scheduler #(
    .W_BITS (W),
    .N_BITS (N),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_w0     (req_w0),
    .req_w1     (req_w1),
    .dec_w      (dec_w),
    .dec_start  (dec_start),
    .dec_found  (dec_found),
    .dec_n      (dec_n),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_n      (rsp_n),
    .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    int           d;
    bit           stale;
    int           hold;
    logic [N-1:0] nval;
    bit           eid;
    logic [N-1:0] en;
    bit           eto;
    int           elat;
  } vec_t;

  vec_t tbl [9];

  int checks;
  int failures;
  int cyc;
  int done_cnt;

  bit           busy;
  bit           last;
  int           t_a;
  int           t_d;
  int           t_start;
  int           t_hold;
  bit           t_stale;
  bit           t_id;
  bit           t_timed;
  logic [W-1:0] t_word;
  logic [N-1:0] t_nval;

  bit           directed;
  logic [1:0]   drv_valid;
  logic [W-1:0] drv_w0;
  logic [W-1:0] drv_w1;
  int           drv_d;
  bit           drv_stale;
  int           drv_hold;
  logic [N-1:0] drv_nval;

  int           obs_lat;
  bit           obs_id;
  bit           obs_to;
  logic [N-1:0] obs_n;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                 nm, cyc, act, exp);
    end
  endtask

  task automatic drive();
    int c;
    c = cyc;
    if (directed) begin
      req_valid = drv_valid;
      req_w0    = drv_w0;
      req_w1    = drv_w1;
    end else begin
      req_valid = 2'($urandom_range(0, 3));
      req_w0    = W'({$urandom, $urandom});
      req_w1    = W'({$urandom, $urandom});
    end
    if (busy && c >= t_a + 1 && c <= t_a + 2)
      dec_found = t_stale;
    else if (busy && c >= t_a + 3)
      dec_found = (c >= t_a + 3 + t_d);
    else
      dec_found = directed ? 1'b0 : 1'($urandom_range(0, 1));
    if (busy && c >= t_a + 3 + t_d)
      dec_n = t_nval;
    else
      dec_n = N'($urandom);
    if (busy && c >= t_start)
      rsp_ready = directed ? (c >= t_start + t_hold)
                           : ($urandom_range(0, 3) != 0);
    else
      rsp_ready = directed ? 1'b0 : 1'($urandom_range(0, 1));
  endtask

  task automatic check_update();
    int         c;
    bit         gv;
    bit         g;
    bit         ev;
    logic [1:0] er;
    c  = cyc;
    gv = 1'b0;
    g  = 1'b0;
    er = 2'b00;
    if (!busy) begin
      if (req_valid == 2'b11) begin
        g  = ~last;
        gv = 1'b1;
      end else if (req_valid == 2'b10) begin
        g  = 1'b1;
        gv = 1'b1;
      end else if (req_valid == 2'b01) begin
        g  = 1'b0;
        gv = 1'b1;
      end
      if (gv) er = 2'b01 << g;
    end
    ev = busy && (c >= t_start);
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("dec_start", 64'(dec_start), 64'(busy && c == t_a + 1));
    chk("dec_w", 64'(dec_w), 64'(t_word));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      chk("rsp_id", 64'(rsp_id), 64'(t_id));
      chk("rsp_n", 64'(rsp_n), t_timed ? 64'({N{1'b1}}) : 64'(t_nval));
      chk("rsp_timeout", 64'(rsp_timeout), 64'(t_timed));
    end
    if (busy && rsp_valid && obs_lat < 0) begin
      obs_lat = c - t_a;
      obs_id  = rsp_id;
      obs_n   = rsp_n;
      obs_to  = rsp_timeout;
    end
    if (ev && rsp_ready) begin
      busy = 1'b0;
      done_cnt++;
    end else if (!busy && gv) begin
      busy    = 1'b1;
      t_a     = c;
      t_id    = g;
      last    = g;
      t_word  = g ? req_w1 : req_w0;
      obs_lat = -1;
      if (directed) begin
        t_d     = drv_d;
        t_stale = drv_stale;
        t_hold  = drv_hold;
        t_nval  = drv_nval;
      end else begin
        t_d     = $urandom_range(0, 10);
        t_stale = 1'($urandom_range(0, 1));
        t_hold  = 0;
        t_nval  = N'($urandom);
      end
      // found is first usable in WAIT cycle 2+d; timeout fires in WAIT cycle TO
      t_timed = TO_EN && (2 + t_d > TO);
      t_start = t_timed ? t_a + 2 + TO : t_a + 4 + t_d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    drive();
    @(negedge clk);
    check_update();
  endtask

  task automatic run_vec(input int i);
    int start;
    bit ok;
    start     = done_cnt;
    ok        = 1'b0;
    directed  = 1'b1;
    drv_valid = tbl[i].valid;
    drv_w0    = tbl[i].w0;
    drv_w1    = tbl[i].w1;
    drv_d     = tbl[i].d;
    drv_stale = tbl[i].stale;
    drv_hold  = tbl[i].hold;
    drv_nval  = tbl[i].nval;
    for (int k = 0; k < 200; k++) begin
      step();
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    drv_valid = 2'b00;
    chk($sformatf("vec%0d_done", i), 64'(ok), 64'(1));
    chk($sformatf("vec%0d_id", i), 64'(obs_id), 64'(tbl[i].eid));
    chk($sformatf("vec%0d_n", i), 64'(obs_n), 64'(tbl[i].en));
    chk($sformatf("vec%0d_to", i), 64'(obs_to), 64'(tbl[i].eto));
    chk($sformatf("vec%0d_lat", i), 64'(obs_lat), 64'(tbl[i].elat));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_dec_w"}, 64'(dec_w), 64'(0));
    chk({tag, "_dec_start"}, 64'(dec_start), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'(0));
    chk({tag, "_rsp_n"}, 64'(rsp_n), 64'(0));
    chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(0));
  endtask

  task automatic model_reset();
    busy    = 1'b0;
    last    = 1'b1;
    t_word  = '0;
    t_a     = 0;
    t_d     = 0;
    t_start = 0;
    t_hold  = 0;
    obs_lat = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    done_cnt  = 0;
    directed  = 1'b1;
    drv_valid = 2'b00;
    drv_w0    = '0;
    drv_w1    = '0;
    drv_d     = 0;
    drv_stale = 1'b0;
    drv_hold  = 0;
    drv_nval  = '0;
    t_stale   = 1'b0;
    t_id      = 1'b0;
    t_timed   = 1'b0;
    t_nval    = '0;
    obs_id    = 1'b0;
    obs_to    = 1'b0;
    obs_n     = '0;
    model_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_w0    = '0;
    req_w1    = '0;
    dec_found = 1'b0;
    dec_n     = '0;
    rsp_ready = 1'b0;

    tbl[0] = '{2'b01, 36'd0,   36'd0,   5,  1'b0, 0,  29'd268435455,
               1'b0, 29'd268435455, 1'b0, 9};
    tbl[1] = '{2'b11, 36'd100, 36'd200, 0,  1'b0, 0,  29'd200,
               1'b1, 29'd200, 1'b0, 4};
    tbl[2] = '{2'b11, 36'd100, 36'd200, 1,  1'b0, 0,  29'd100,
               1'b0, 29'd100, 1'b0, 5};
    tbl[3] = '{2'b11, 36'd100, 36'd200, 0,  1'b0, 0,  29'd200,
               1'b1, 29'd200, 1'b0, 4};
    tbl[4] = '{2'b10, 36'd11,  36'd22,  0,  1'b1, 0,  29'd7,
               1'b1, 29'd7, 1'b0, 4};
    tbl[5] = '{2'b01, 36'd33,  36'd44,  2,  1'b0, 10, 29'd55,
               1'b0, 29'd55, 1'b0, 6};
`ifdef SEC_SCHED_TIMEOUT_EN
    tbl[6] = '{2'b01, 36'd5,   36'd6,   12, 1'b0, 0,  29'd99,
               1'b0, 29'h1FFF_FFFF, 1'b1, 10};
`else
    tbl[6] = '{2'b01, 36'd5,   36'd6,   12, 1'b0, 0,  29'd99,
               1'b0, 29'd99, 1'b0, 16};
`endif
    tbl[7] = '{2'b01, 36'd8,   36'd9,   6,  1'b1, 0,  29'd77,
               1'b0, 29'd77, 1'b0, 10};
    tbl[8] = '{2'b11, 36'd300, 36'd400, 0,  1'b0, 0,  29'd5,
               1'b0, 29'd5, 1'b0, 4};

    #2;
    chk_reset_vals("por");
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i);

    directed = 1'b0;
    repeat (3000) step();

    directed  = 1'b1;
    drv_valid = 2'b00;
    ok        = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("drain", 64'(ok), 64'(1));

    drv_valid = 2'b01;
    drv_w0    = 36'hA_BCDE_F012;
    drv_d     = 10;
    drv_stale = 1'b0;
    drv_hold  = 0;
    drv_nval  = 29'd3;
    ok        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy && cyc == t_a + 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_wait", 64'(ok), 64'(1));
    drv_valid = 2'b00;
    req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    #4;
    rst_n = 1'b1;
    model_reset();

    run_vec(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sec_decode_scheduler.md
# sec_decode_scheduler

Sequencer and two-way arbiter in front of the clocked SEC location decoder (36-bit codeword in, 29-bit location out, `found` completion flag). It accepts codewords from two requesters, issues one word at a time to the decoder, and holds the word stable until `found` or a timeout. It returns the location plus the requester ID over a valid/ready response channel. It sits between the memory read path and the single shared decoder instance.

## Interface
- `W_BITS`, 36: codeword width.
- `N_BITS`, 29: location/result width.
- `TIMEOUT`, 64: maximum WAIT cycles before abort; must satisfy 2 ≤ TIMEOUT ≤ 255.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  2: per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2: per-requester accept; a request transfers when `req_valid[i] & req_ready[i]`.
- `req_w0`  in  W_BITS: codeword from requester 0.
- `req_w1`  in  W_BITS: codeword from requester 1.
- `dec_w`  out  W_BITS: codeword driven to the decoder `W` port; registered.
- `dec_start`  out  1: one-cycle pulse marking a new word on `dec_w`.
- `dec_found`  in  1: decoder `found`.
- `dec_n`  in  N_BITS: decoder `N`.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response accept.
- `rsp_id`  out  1: requester that issued the word.
- `rsp_n`  out  N_BITS: captured location.
- `rsp_timeout`  out  1: response produced by timeout; `rsp_n` is all-ones in that case.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when any `req_valid` is high.
  - ISSUE → WAIT always.
  - WAIT → RESP on `dec_found` (when not blanked) or on timeout.
  - RESP → IDLE on `rsp_ready`.
- Arbitration: round-robin on a 1-bit `last_grant` register.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
  - When both are valid, grant `~last_grant`; otherwise grant the single valid requester.
  - `last_grant` updates on grant.
- `req_ready[g]` is high only in IDLE, only for the granted g, and only in the same cycle as the arbitration decision. At most one bit is ever high.
- On accept, the block registers `dec_w` and the ID and moves to ISSUE.
  - `dec_start` = 1 during ISSUE.
  - `dec_w` holds its value until the next accept; it is never changed during WAIT.
- WAIT:
  - The first WAIT cycle is blanked: `dec_found` is ignored, so a stale level from the previous word is never attributed to the new one.
  - From the second WAIT cycle, `dec_found` = 1 captures `dec_n` into `rsp_n`, sets `rsp_timeout` = 0, and moves to RESP.
- Timeout counter:
  - 8-bit, cleared on entry to WAIT, increments each WAIT cycle.
  - When count == TIMEOUT-1 and there is no `found`, go to RESP with `rsp_n` = all-ones and `rsp_timeout` = 1.
  - If `found` and timeout occur in the same cycle, `found` wins.
- RESP: `rsp_valid` = 1. `rsp_n`, `rsp_id` and `rsp_timeout` are stable until `rsp_ready`. No new request is accepted while in RESP.
- Reset mid-operation: everything returns to IDLE immediately and any in-flight word is dropped without a response.

## Timing
- Reset values:
  - `req_ready` = 0, `dec_w` = 0, `dec_start` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_n` = 0, `rsp_timeout` = 0.
  - FSM = IDLE, `last_grant` = 1.
- Accept edge T: `dec_w` valid and `dec_start` = 1 in cycle T+1; WAIT begins at T+2.
- `found` first seen high in WAIT cycle k (k ≥ 2) gives `rsp_valid` = 1 in the next cycle.
- Best-case accept-to-`rsp_valid` latency is 4 cycles.
- Throughput is one word per (4 + decoder latency + response stall) cycles; there is no overlap.
- With `rsp_ready` tied high, RESP lasts exactly one cycle and IDLE can accept again in the following cycle.

## Configuration
- `SEC_SCHED_TIMEOUT_EN`:
  - Defined: the timeout counter and abort path exist as described, and `rsp_timeout` is functional.
  - Undefined: the counter is removed, WAIT leaves only on `dec_found`, `rsp_timeout` is tied 0, and `TIMEOUT` is unused.

## Structure
- Shared package `sec_sched_pkg`:
  - FSM state enum (`S_IDLE`, `S_ISSUE`, `S_WAIT`, `S_RESP`).
  - Default widths `W_BITS`/`N_BITS`.
  - Constant `SEC_NOT_FOUND` = all-ones N_BITS.
- One sub-module, `sec_rr_arb2`: combinational 2-way round-robin grant from `req_valid` and `last_grant`, outputting a one-hot grant and a grant index. The FSM, datapath registers and counter stay in the top.

## Test plan
- Single request: requester 0, `req_w0` = 0; the decoder model raises `found` with `dec_n` = 268435455 after 5 cycles → `rsp_valid` with `rsp_id` = 0, `rsp_n` = 268435455, `rsp_timeout` = 0, 4 + 5 cycles after accept.
- Contention: both requesters valid continuously, with words 100 and 200 → grants alternate 0,1,0,1. Responses carry IDs in that order, and `dec_w` changes only at `dec_start`.
- Stale found: `dec_found` held at 1 across ISSUE and the first WAIT cycle → no capture in the blanked cycle; capture in the second WAIT cycle.
- Timeout (`SEC_SCHED_TIMEOUT_EN` defined, TIMEOUT = 8): `found` never asserts → after 8 WAIT cycles `rsp_timeout` = 1 and `rsp_n` = 2^29−1. Also: `found` arriving on the 8th cycle → `rsp_timeout` = 0.
- Backpressure: `rsp_ready` held low for 10 cycles → `rsp_*` stable, `req_ready` = 00 throughout; release gives one transfer, then IDLE.
- Reset during WAIT: pulse `rst_n` low for 5 ns mid-WAIT → all outputs at reset values asynchronously, no response emitted, and the next request is granted to requester 0.
